// File: rtl/hazard_pipeline_controller.sv
// Hazard controller for the 5-stage pipeline: load-use stall FSM, branch flush,
// EX>MEM>WB operand forwarding and saturating stall/flush event counters.
module hazard_pipeline_controller #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [REG_W-1:0] ID_Rn,
    input  logic [REG_W-1:0] ID_Rm,
    input  logic [REG_W-1:0] ID_Rd,
    input  logic             ID_use_Rn,
    input  logic             ID_use_Rm,
    input  logic             ID_use_Rd,
    input  logic             ID_B_taken,
    input  logic [REG_W-1:0] EX_Rd,
    input  logic             EX_RF_enable,
    input  logic             EX_Load_Inst,
    input  logic [REG_W-1:0] MEM_Rd,
    input  logic             MEM_RF_enable,
    input  logic [REG_W-1:0] WB_Rd,
    input  logic             WB_RF_enable,
    output logic             PC_Ld,
    output logic             IFID_Ld,
    output logic             CU_nop_sel,
    output logic             IFID_flush,
    output logic [1:0]       FWD_A,
    output logic [1:0]       FWD_B,
    output logic [1:0]       FWD_C,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {RUN, STALL} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             flush;

    // R15 is the PC: it is never a forwarding or stall source
    function automatic logic match(input logic use_x, input logic [REG_W-1:0] x,
                                   input logic en, input logic [REG_W-1:0] rd);
        return use_x & en & (rd == x) & (x != '1);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic use_x, input logic [REG_W-1:0] x,
                                           input logic ex_en, input logic [REG_W-1:0] ex_rd,
                                           input logic mem_en, input logic [REG_W-1:0] mem_rd,
                                           input logic wb_en, input logic [REG_W-1:0] wb_rd);
        if (match(use_x, x, ex_en, ex_rd))   return 2'b01;
        if (match(use_x, x, mem_en, mem_rd)) return 2'b10;
        if (match(use_x, x, wb_en, wb_rd))   return 2'b11;
        return 2'b00;
    endfunction

    always_comb begin
        // EX holds a bubble while in STALL, so load-use is only checked in RUN
        load_use = (state_q == RUN) & EX_Load_Inst &
                   (match(ID_use_Rn, ID_Rn, EX_RF_enable, EX_Rd) |
                    match(ID_use_Rm, ID_Rm, EX_RF_enable, EX_Rd) |
                    match(ID_use_Rd, ID_Rd, EX_RF_enable, EX_Rd));
        flush = ID_B_taken & ~load_use;

        state_d     = load_use ? STALL : RUN;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (load_use && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush && flush_cnt_q != '1)    flush_cnt_d = flush_cnt_q + CNT_W'(1);

        PC_Ld      = ~load_use;
        IFID_Ld    = ~load_use;
        CU_nop_sel = load_use;
        IFID_flush = flush;
        FWD_A = fwd_sel(ID_use_Rn, ID_Rn, EX_RF_enable, EX_Rd, MEM_RF_enable, MEM_Rd,
                        WB_RF_enable, WB_Rd);
        FWD_B = fwd_sel(ID_use_Rm, ID_Rm, EX_RF_enable, EX_Rd, MEM_RF_enable, MEM_Rd,
                        WB_RF_enable, WB_Rd);
        FWD_C = fwd_sel(ID_use_Rd, ID_Rd, EX_RF_enable, EX_Rd, MEM_RF_enable, MEM_Rd,
                        WB_RF_enable, WB_Rd);

        // Pipeline is frozen with bubbles injected while reset is held
        if (!CLR) begin
            PC_Ld      = 1'b0;
            IFID_Ld    = 1'b0;
            CU_nop_sel = 1'b1;
            IFID_flush = 1'b0;
            FWD_A      = 2'b00;
            FWD_B      = 2'b00;
            FWD_C      = 2'b00;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_pipeline_controller.sv
// Scoreboard bench for hazard_pipeline_controller: directed scenarios then random
// traffic, all checked against a rule-level reference model.
module tb_hazard_pipeline_controller;

    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        bit       clr;
        bit [3:0] rn, rm, rd;
        bit       use_rn, use_rm, use_rd, b_taken;
        bit [3:0] ex_rd;
        bit       ex_en, ex_load;
        bit [3:0] mem_rd;
        bit       mem_en;
        bit [3:0] wb_rd;
        bit       wb_en;
    } stim_t;

    typedef struct packed {
        bit             pc, ifid, nop, flush;
        bit [1:0]       fa, fb, fc;
        bit [CNT_W-1:0] sc, fcnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    stim_t cur = '0;
    logic             PC_Ld, IFID_Ld, CU_nop_sel, IFID_flush;
    logic [1:0]       FWD_A, FWD_B, FWD_C;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    exp_t             act;

    hazard_pipeline_controller #(.REG_W(4), .CNT_W(CNT_W)) dut (
        .CLK(clk), .CLR(cur.clr),
        .ID_Rn(cur.rn), .ID_Rm(cur.rm), .ID_Rd(cur.rd),
        .ID_use_Rn(cur.use_rn), .ID_use_Rm(cur.use_rm), .ID_use_Rd(cur.use_rd),
        .ID_B_taken(cur.b_taken),
        .EX_Rd(cur.ex_rd), .EX_RF_enable(cur.ex_en), .EX_Load_Inst(cur.ex_load),
        .MEM_Rd(cur.mem_rd), .MEM_RF_enable(cur.mem_en),
        .WB_Rd(cur.wb_rd), .WB_RF_enable(cur.wb_en),
        .PC_Ld(PC_Ld), .IFID_Ld(IFID_Ld), .CU_nop_sel(CU_nop_sel), .IFID_flush(IFID_flush),
        .FWD_A(FWD_A), .FWD_B(FWD_B), .FWD_C(FWD_C),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign act = {PC_Ld, IFID_Ld, CU_nop_sel, IFID_flush, FWD_A, FWD_B, FWD_C,
                  stall_cnt, flush_cnt};

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // reference model state
    bit m_in_stall = 0;
    int m_sc = 0;
    int m_fc = 0;

    function automatic bit hit(bit u, bit [3:0] x, bit en, bit [3:0] rd);
        return u && x != 4'd15 && en && rd == x;
    endfunction

    function automatic bit [1:0] src(bit u, bit [3:0] x, stim_t s);
        bit       en[3];
        bit [3:0] rd[3];
        en[0] = s.ex_en;  rd[0] = s.ex_rd;
        en[1] = s.mem_en; rd[1] = s.mem_rd;
        en[2] = s.wb_en;  rd[2] = s.wb_rd;
        for (int i = 0; i < 3; i++)
            if (hit(u, x, en[i], rd[i])) return 2'(i + 1);
        return 2'd0;
    endfunction

    function automatic stim_t idle();
        stim_t s = '0;
        s.clr = 1'b1;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   stall;
        @(posedge clk); #1;
        cur = s;
        cyc++;
        if (!s.clr) begin
            m_in_stall = 0; m_sc = 0; m_fc = 0;
        end
        e.sc   = CNT_W'(m_sc);
        e.fcnt = CNT_W'(m_fc);
        if (!s.clr) begin
            e.pc = 0; e.ifid = 0; e.nop = 1; e.flush = 0;
            e.fa = 0; e.fb = 0; e.fc = 0;
        end else begin
            stall = !m_in_stall && s.ex_load &&
                    (hit(s.use_rn, s.rn, s.ex_en, s.ex_rd) ||
                     hit(s.use_rm, s.rm, s.ex_en, s.ex_rd) ||
                     hit(s.use_rd, s.rd, s.ex_en, s.ex_rd));
            e.pc    = !stall;
            e.ifid  = !stall;
            e.nop   = stall;
            e.flush = s.b_taken && !stall;
            e.fa    = src(s.use_rn, s.rn, s);
            e.fb    = src(s.use_rm, s.rm, s);
            e.fc    = src(s.use_rd, s.rd, s);
            m_in_stall = stall;
            if (stall && m_sc < CMAX) m_sc++;
            if (e.flush && m_fc < CMAX) m_fc++;
        end
        q.push_back(e);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            n_tests++;
            if (act !== mon_e) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d got pc=%b ifid=%b nop=%b fl=%b fwd=%0d/%0d/%0d sc=%0d fc=%0d exp pc=%b ifid=%b nop=%b fl=%b fwd=%0d/%0d/%0d sc=%0d fc=%0d",
                         cyc, act.pc, act.ifid, act.nop, act.flush, act.fa, act.fb, act.fc,
                         act.sc, act.fcnt, mon_e.pc, mon_e.ifid, mon_e.nop, mon_e.flush,
                         mon_e.fa, mon_e.fb, mon_e.fc, mon_e.sc, mon_e.fcnt);
            end
        end
    end

    function automatic bit [3:0] rreg();
        int v = $urandom_range(0, 4);
        return (v == 4) ? 4'd15 : 4'(v);
    endfunction

    initial begin
        stim_t s;
        // reset held 3 cycles, with hazard-looking inputs that must be ignored
        s = idle(); s.clr = 0; s.ex_load = 1; s.ex_en = 1; s.ex_rd = 3;
        s.use_rm = 1; s.rm = 3; s.b_taken = 1;
        repeat (3) step(s);
        repeat (2) step(idle());

        // EX beats MEM on the same register
        s = idle(); s.ex_rd = 5; s.ex_en = 1; s.mem_rd = 5; s.mem_en = 1;
        s.rn = 5; s.use_rn = 1;
        step(s);
        s.ex_en = 0; step(s);
        s.mem_en = 0; s.wb_rd = 5; s.wb_en = 1; step(s);

        // load-use on Rm: stall, then MEM forward, then back to RUN
        s = idle(); s.ex_load = 1; s.ex_en = 1; s.ex_rd = 3; s.rm = 3; s.use_rm = 1;
        step(s);
        s = idle(); s.mem_rd = 3; s.mem_en = 1; s.rm = 3; s.use_rm = 1;
        step(s);
        step(idle());

        // branch alone, then branch colliding with load-use
        s = idle(); s.b_taken = 1; step(s);
        step(idle());
        s = idle(); s.b_taken = 1; s.ex_load = 1; s.ex_en = 1; s.ex_rd = 7;
        s.rd = 7; s.use_rd = 1;
        step(s);
        s = idle(); s.b_taken = 1; s.mem_rd = 7; s.mem_en = 1; s.rd = 7; s.use_rd = 1;
        step(s);
        step(idle());

        // R15 never stalls or forwards
        s = idle(); s.rn = 15; s.use_rn = 1; s.ex_rd = 15; s.ex_en = 1; s.ex_load = 1;
        s.mem_rd = 15; s.mem_en = 1;
        step(s);

        // repeated load-use saturates stall_cnt, then reset lands inside STALL
        s = idle(); s.ex_load = 1; s.ex_en = 1; s.ex_rd = 2; s.rn = 2; s.use_rn = 1;
        repeat (21) step(s);
        s.clr = 0; step(s);
        s.clr = 1; repeat (3) step(s);
        s = idle(); s.b_taken = 1;
        repeat (10) step(s);

        // random traffic with occasional resets
        repeat (3000) begin
            s.clr     = ($urandom_range(0, 59) != 0);
            s.rn      = rreg(); s.rm = rreg(); s.rd = rreg();
            s.use_rn  = $urandom_range(0, 1) != 0;
            s.use_rm  = $urandom_range(0, 1) != 0;
            s.use_rd  = $urandom_range(0, 3) == 0;
            s.b_taken = $urandom_range(0, 5) == 0;
            s.ex_rd   = rreg(); s.ex_en = $urandom_range(0, 1) != 0;
            s.ex_load = $urandom_range(0, 2) == 0;
            s.mem_rd  = rreg(); s.mem_en = $urandom_range(0, 1) != 0;
            s.wb_rd   = rreg(); s.wb_en = $urandom_range(0, 1) != 0;
            step(s);
        end

        @(negedge clk); @(negedge clk);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
